// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: FSM states,
// reset address default and instruction field widths.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          OFFSET_W         = 16;
  localparam int          JTARGET_W        = 26;

endpackage

// File: rtl/pc_plus1.sv
// PCPlus1 incrementer: word address plus one, wrapping modulo 2^32.
module pc_plus1 (
  input  logic [31:0] pc,
  output logic [31:0] pc_next1
);

  assign pc_next1 = pc + 32'd1;

endmodule

// File: rtl/pc_sequencer_next_pc_mux.sv
// Redirect priority (jump-register > jump > branch > sequential) and the
// target arithmetic for the next fetch address.
module next_pc_mux
  import pc_sequencer_pkg::*;
(
  input  logic [31:0]          pc_next1,
  input  logic                 branch,
  input  logic [OFFSET_W-1:0]  branch_offset,
  input  logic                 jump,
  input  logic [JTARGET_W-1:0] jump_target,
  input  logic                 jump_reg,
  input  logic [31:0]          reg_target,
  output logic [31:0]          next_pc
);

  logic [31:0] offset_ext;

  assign offset_ext = {{(32-OFFSET_W){branch_offset[OFFSET_W-1]}}, branch_offset};

  // Pick the highest-priority redirect; the branch add wraps silently.
  always_comb begin
    next_pc = pc_next1;
    if (jump_reg) begin
      next_pc = reg_target;
    end else if (jump) begin
      next_pc = {pc_next1[31:JTARGET_W], jump_target};
    end else if (branch) begin
      next_pc = pc_next1 + offset_ext;
    end else begin
      next_pc = pc_next1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage: PC register, boot/run/halted FSM and the
// retired-instruction counter.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 Stall,
  input  logic                 Halt,
  input  logic                 Branch,
  input  logic [OFFSET_W-1:0]  BranchOffset,
  input  logic                 Jump,
  input  logic [JTARGET_W-1:0] JumpTarget,
  input  logic                 JumpReg,
  input  logic [31:0]          RegTarget,
  output logic [31:0]          PC,
  output logic [31:0]          PCNext1,
  output logic                 PCValid,
  output logic                 Halted,
  output logic [CNT_W-1:0]     RetiredCount
);

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_r, state_n;
  logic [31:0]      pc_r, pc_n;
  logic [31:0]      mux_pc_s;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic             pc_valid_r;
  logic             halted_r;

  pc_plus1 u_pc_plus1 (
    .pc       (pc_r),
    .pc_next1 (PCNext1)
  );

  next_pc_mux u_next_pc_mux (
    .pc_next1      (PCNext1),
    .branch        (Branch),
    .branch_offset (BranchOffset),
    .jump          (Jump),
    .jump_target   (JumpTarget),
    .jump_reg      (JumpReg),
    .reg_target    (RegTarget),
    .next_pc       (mux_pc_s)
  );

  // Next-state logic: stall outranks halt, halt outranks any redirect.
  always_comb begin
    state_n = state_r;
    pc_n    = pc_r;
    cnt_n   = cnt_r;
    case (state_r)
      ST_BOOT: begin
        state_n = ST_RUN;
      end
      ST_RUN: begin
        if (Stall) begin
          state_n = ST_RUN;
        end else if (Halt) begin
          state_n = ST_HALTED;
          cnt_n   = cnt_r + CNT_ONE;
        end else begin
          pc_n  = mux_pc_s;
          cnt_n = cnt_r + CNT_ONE;
        end
      end
      ST_HALTED: begin
        state_n = ST_HALTED;
      end
      default: begin
        state_n = ST_BOOT;
      end
    endcase
  end

  // State, PC, counter and the status flags that follow the next state.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_r    <= ST_BOOT;
      pc_r       <= RESET_PC;
      cnt_r      <= CNT_ZERO;
      pc_valid_r <= 1'b0;
      halted_r   <= 1'b0;
    end else begin
      state_r    <= state_n;
      pc_r       <= pc_n;
      cnt_r      <= cnt_n;
      pc_valid_r <= (state_n == ST_RUN);
      halted_r   <= (state_n == ST_HALTED);
    end
  end

  assign PC           = pc_r;
  assign PCValid      = pc_valid_r;
  assign Halted       = halted_r;
  assign RetiredCount = cnt_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: two sequencers (default reset address, and a wrapping
// reset address with a narrow counter) compared against a behavioural model.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Stall = 1'b0, Halt = 1'b0, Branch = 1'b0, Jump = 1'b0, JumpReg = 1'b0;
  logic [15:0] BranchOffset = 16'h0;
  logic [25:0] JumpTarget = 26'h0;
  logic [31:0] RegTarget = 32'h0;

  logic [31:0] pc0, nx0, cnt0;
  logic        v0, h0;
  logic [31:0] pc1, nx1;
  logic [3:0]  cnt1;
  logic        v1, h1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(32)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Halt(Halt), .Branch(Branch),
    .BranchOffset(BranchOffset), .Jump(Jump), .JumpTarget(JumpTarget),
    .JumpReg(JumpReg), .RegTarget(RegTarget), .PC(pc0), .PCNext1(nx0),
    .PCValid(v0), .Halted(h0), .RetiredCount(cnt0)
  );

  pc_sequencer #(.RESET_PC(32'hFFFF_FFFE), .CNT_W(4)) u_wrap (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Halt(Halt), .Branch(Branch),
    .BranchOffset(BranchOffset), .Jump(Jump), .JumpTarget(JumpTarget),
    .JumpReg(JumpReg), .RegTarget(RegTarget), .PC(pc1), .PCNext1(nx1),
    .PCValid(v1), .Halted(h1), .RetiredCount(cnt1)
  );

  // Behavioural model: one entry per instance.
  logic [31:0] m_pc[2];
  logic [31:0] m_cnt[2];
  logic        m_boot[2];
  logic        m_halt[2];
  logic [31:0] m_rpc[2];
  logic [31:0] m_cmask[2];
  bit          m_ok = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (!Rst_n) begin
        m_pc[i] = m_rpc[i]; m_cnt[i] = 32'd0; m_boot[i] = 1'b1; m_halt[i] = 1'b0;
      end else if (m_boot[i]) begin
        m_boot[i] = 1'b0;
      end else if (!m_halt[i] && !Stall) begin
        m_cnt[i] = (m_cnt[i] + 32'd1) & m_cmask[i];
        if (Halt)         m_halt[i] = 1'b1;
        else if (JumpReg) m_pc[i] = RegTarget;
        else if (Jump)    m_pc[i] = {m_pc[i][31:26] + 6'd0, JumpTarget} + ((m_pc[i] == 32'hFFFF_FFFF) ? 32'd0 : 32'd0) +
                                    (((m_pc[i] + 32'd1) & 32'hFC00_0000) - (m_pc[i] & 32'hFC00_0000));
        else if (Branch)  m_pc[i] = m_pc[i] + 32'd1 + 32'($signed(BranchOffset));
        else              m_pc[i] = m_pc[i] + 32'd1;
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_step();
    m_ok = 1'b1;
    @(negedge Clk);
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge Clk) begin
    if (m_ok) begin
      chk("pc0", pc0, m_pc[0]);
      chk("next0", nx0, m_pc[0] + 32'd1);
      chk("valid0", {31'd0, v0}, {31'd0, !m_boot[0] && !m_halt[0]});
      chk("halted0", {31'd0, h0}, {31'd0, m_halt[0]});
      chk("cnt0", cnt0, m_cnt[0]);
      chk("pc1", pc1, m_pc[1]);
      chk("next1", nx1, m_pc[1] + 32'd1);
      chk("valid1", {31'd0, v1}, {31'd0, !m_boot[1] && !m_halt[1]});
      chk("halted1", {31'd0, h1}, {31'd0, m_halt[1]});
      chk("cnt1", {28'd0, cnt1}, m_cnt[1] & 32'hF);
    end
  end

  initial begin
    m_rpc[0] = 32'h0000_0000; m_cmask[0] = 32'hFFFF_FFFF;
    m_rpc[1] = 32'hFFFF_FFFE; m_cmask[1] = 32'h0000_000F;
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 32'd0; m_cnt[i] = 32'd0; m_boot[i] = 1'b1; m_halt[i] = 1'b0;
    end

    // Reset and boot
    Rst_n = 1'b0;
    tick(); tick();
    chk("rst_pc", pc0, 32'h0);
    chk("rst_valid", {31'd0, v0}, 32'd0);
    chk("rst_wrap_pc", pc1, 32'hFFFF_FFFE);
    Rst_n = 1'b1;
    tick();
    chk("boot_pc", pc0, 32'h0);
    chk("boot_valid", {31'd0, v0}, 32'd1);
    tick();
    chk("seq_pc", pc0, 32'h1);
    chk("seq_cnt", cnt0, 32'd1);
    chk("wrap_pc_a", pc1, 32'hFFFF_FFFF);
    tick();
    chk("wrap_pc_b", pc1, 32'h0000_0000);
    chk("wrap_cnt", {28'd0, cnt1}, 32'd2);

    // Redirect priority
    JumpReg = 1'b1; RegTarget = 32'h100;
    tick();
    chk("jr_pc", pc0, 32'h100);
    JumpReg = 1'b0; Branch = 1'b1; BranchOffset = 16'hFFF0;
    tick();
    chk("branch_back", pc0, 32'hF1);
    Jump = 1'b1; JumpTarget = 26'h3;
    tick();
    chk("jump_over_branch", pc0, 32'h3);
    JumpReg = 1'b1; RegTarget = 32'h40;
    tick();
    chk("jr_over_jump", pc0, 32'h40);
    JumpReg = 1'b0; Jump = 1'b0; Branch = 1'b0;

    // Stall holds everything, then the pending branch applies
    JumpReg = 1'b1; RegTarget = 32'h10;
    tick();
    JumpReg = 1'b0; Stall = 1'b1; Branch = 1'b1; BranchOffset = 16'h0005;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_pc", pc0, 32'h10);
    end
    Stall = 1'b0;
    tick();
    chk("post_stall_branch", pc0, 32'h16);
    BranchOffset = 16'hFFFF;
    tick();
    chk("self_loop", pc0, 32'h16);
    Branch = 1'b0;

    // Halt, ignored redirects, reset out of HALTED
    JumpReg = 1'b1; RegTarget = 32'h20;
    tick();
    JumpReg = 1'b0; Halt = 1'b1;
    tick();
    chk("halt_pc", pc0, 32'h20);
    chk("halt_flag", {31'd0, h0}, 32'd1);
    chk("halt_valid", {31'd0, v0}, 32'd0);
    Halt = 1'b0; Jump = 1'b1; Branch = 1'b1; JumpTarget = 26'h155;
    tick(); tick();
    chk("halted_frozen", pc0, 32'h20);
    Jump = 1'b0; Branch = 1'b0; Rst_n = 1'b0;
    tick();
    chk("halt_rst_pc", pc0, 32'h0);
    chk("halt_rst_flag", {31'd0, h0}, 32'd0);
    chk("halt_rst_cnt", cnt0, 32'd0);

    // Reset in the middle of a stall
    Rst_n = 1'b1;
    tick(); tick();
    Stall = 1'b1;
    tick();
    Rst_n = 1'b0;
    tick();
    chk("stall_rst_pc", pc1, 32'hFFFF_FFFE);
    chk("stall_rst_valid", {31'd0, v0}, 32'd0);
    Rst_n = 1'b1; Stall = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      Rst_n        = ($urandom_range(63) != 0);
      Stall        = ($urandom_range(3) == 0);
      Halt         = ($urandom_range(40) == 0);
      Branch       = $urandom_range(1) == 1;
      Jump         = ($urandom_range(3) == 0);
      JumpReg      = ($urandom_range(4) == 0);
      BranchOffset = 16'($urandom);
      JumpTarget   = 26'($urandom);
      RegTarget    = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(15)) : 32'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Program-counter stage of the single-cycle MIPS datapath. Holds the word-addressed PC register and drives it into instruction memory and the PCPlus1 incrementer.
- Consumes PCPlus1's output and selects the next PC from four sources: sequential, branch, jump, or jump-register.
- Adds a boot cycle, a stall hold, a halt state, and a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word address).
- CNT_W, 32, width of RetiredCount.

Ports:
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst_n  input  1  synchronous reset, active-low (one clock; reset is synchronous and active-low).
- Stall  input  1  hold PC this cycle.
- Halt  input  1  current instruction is HALT; stop fetching after it.
- Branch  input  1  taken conditional branch.
- BranchOffset  input  16  signed word offset, relative to PC+1.
- Jump  input  1  J/JAL.
- JumpTarget  input  26  instruction-word index field.
- JumpReg  input  1  JR/JALR.
- RegTarget  input  32  rs value (word address).
- PC  output  32  current fetch address.
- PCNext1  output  32  PC+1, for the JAL link value.
- PCValid  output  1  PC holds a real instruction address this cycle.
- Halted  output  1  sequencer is in HALTED.
- RetiredCount  output  CNT_W  number of instructions completed.

Behaviour:
- Reset (Rst_n=0 at a rising edge, from any state, including mid-stall or HALTED):
  - PC=RESET_PC, state=BOOT, RetiredCount=0.
  - PCValid=0, Halted=0.
  - Reset overrides every other input.
- States:
  - BOOT: one cycle, PCValid=0, PC held. Next state is always RUN.
  - RUN: PCValid=1. Advances or holds per the priority rules below.
  - HALTED: PCValid=0, Halted=1. PC frozen at the HALT instruction address. Ignores every input except Rst_n.
- RUN priority, evaluated each edge:
  1. Stall=1: PC, state and RetiredCount hold. All other inputs are ignored, including Halt.
  2. Halt=1: PC holds, state->HALTED, RetiredCount+1.
  3. JumpReg=1: PC<=RegTarget.
  4. Jump=1: PC<={PCNext1[31:26], JumpTarget}.
  5. Branch=1: PC<=PCNext1 + sign-extend(BranchOffset).
  6. Otherwise: PC<=PCNext1.
  - Cases 3-6 also increment RetiredCount by 1.
  - Multiple redirects asserted together resolve by this fixed priority; no error is flagged.
- Arithmetic:
  - PCNext1=PC+1, modulo 2^32: 32'hFFFF_FFFF -> 0.
  - Branch add is 32-bit two's-complement and wraps silently. Offset 16'hFFFF means target = PC, i.e. a self-loop.
- RetiredCount wraps to 0 after all-ones; it does not saturate.
- Combinational outputs: PCNext1 is derived from the PC register; PC, PCValid, Halted and RetiredCount are registered.
- Latency: a redirect presented in cycle N appears on PC in cycle N+1.

Decomposition:
- Shared package holds:
  - state encoding constants ST_BOOT=2'd0, ST_RUN=2'd1, ST_HALTED=2'd2.
  - the RESET_PC default.
  - field widths: OFFSET_W=16, JTARGET_W=26.
- Reuse the PCPlus1 incrementer to produce PCNext1.
- One new combinational sub-module, next_pc_mux, holds source priority and target arithmetic. The FSM, PC register and counter stay in pc_sequencer.

Test Plan:
- Reset/boot: Rst_n=0 for 2 cycles, then 1, no other inputs -> cycle 0 PC=0 PCValid=0; cycle 1 PC=0 PCValid=1; cycle 2 PC=1, RetiredCount=1.
- Sequential and wrap: RESET_PC=32'hFFFF_FFFE, run 3 instructions -> PC sequence FFFF_FFFE, FFFF_FFFF, 0000_0000; RetiredCount=2 after the second advance.
- Redirect priority: PC=0x100 with Branch=1, offset=16'hFFF0 -> PC=0xF1. Then Jump=1 with Branch=1, JumpTarget=0x3 -> PC=0x3. Then JumpReg=1 with Jump=1, RegTarget=0x40 -> PC=0x40.
- Stall: PC=0x10, Stall=1 for 3 cycles with Branch=1 -> PC stays 0x10 and RetiredCount is unchanged. Stall drops -> branch applies next edge.
- Halt: PC=0x20, Halt=1 -> PC stays 0x20, Halted=1, PCValid=0, RetiredCount+1. Jump/Branch pulses afterwards -> no change.
- Reset from HALTED/mid-stall: Rst_n=0 while Halted=1 -> next edge PC=RESET_PC, Halted=0, RetiredCount=0, state BOOT.
